// File: rtl/trng_collector_if.sv
// trng_collector_if: groups the TRNG sample handshake, the FIFO read port and
// the health status/clear signals of trng_collector.
// master = the collector, slave = the surrounding system (TRNG source + consumer).
interface trng_collector_if #(
    parameter int TRNG_WIDTH = 4,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic [TRNG_WIDTH-1:0] trng_word;
    logic                  trng_valid;
    logic                  trng_req;
    logic [OUT_WIDTH-1:0]  rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [LEVEL_W-1:0]    level;
    logic                  health_fail;
    logic                  fail_clr;

    modport master (
        input  trng_word, trng_valid, rd_ready, fail_clr,
        output trng_req, rd_data, rd_valid, level, health_fail
    );

    modport slave (
        output trng_word, trng_valid, rd_ready, fail_clr,
        input  trng_req, rd_data, rd_valid, level, health_fail
    );
endinterface

// File: rtl/trng_collector.sv
// trng_collector: assembles raw TRNG samples into OUT_WIDTH words and buffers
// them in a first-word-fall-through FIFO.
// Optional macro TRNG_COLLECTOR_HEALTH_EN compiles in a repetition-count health
// test; without it FAULT is unreachable and health_fail is tied low.
// The parameters must match the ones used for the connected trng_collector_if.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// COLLECT | accepting samples while the FIFO has room (trng_req = level<DEPTH)
// FAULT   | health test tripped; FIFO flushed, requests held off until fail_clr
module trng_collector #(
    parameter int TRNG_WIDTH = 4,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 8
) (
    input logic              clk,
    input logic              reset,
    trng_collector_if.master bus
);
    localparam int SLICES  = OUT_WIDTH / TRNG_WIDTH;
    localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {COLLECT, FAULT} state_t;

    state_t                 state_q;
    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LEVEL_W-1:0]     level_q, level_next;
    logic                   rd_valid_q, trng_req_q, health_fail_q;
    logic [OUT_WIDTH-1:0]   asm_q, asm_next;
    logic [SLICE_W-1:0]     slice_q;
    logic                   accept, last, push, pop, trip;

`ifdef TRNG_COLLECTOR_HEALTH_EN
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    logic [REP_W-1:0]      rep_cnt_q, rep_next;
    logic [TRNG_WIDTH-1:0] prev_q;
`else
    logic unused_rep_limit;
    assign unused_rep_limit = (REP_LIMIT < 2);
`endif

    // Datapath decode: sample acceptance, word completion, FIFO push/pop, health trip.
    always_comb begin
        accept   = trng_req_q & bus.trng_valid;
        last     = (slice_q == SLICE_W'(SLICES - 1));
        asm_next = asm_q;
        asm_next[slice_q*TRNG_WIDTH +: TRNG_WIDTH] = bus.trng_word;
        push     = accept & last;
        pop      = rd_valid_q & bus.rd_ready;
`ifdef TRNG_COLLECTOR_HEALTH_EN
        if (rep_cnt_q == '0 || bus.trng_word != prev_q) begin
            rep_next = REP_W'(1);
        end else begin
            rep_next = rep_cnt_q + REP_W'(1);
        end
        trip = accept && (rep_next == REP_W'(REP_LIMIT));
`else
        trip = 1'b0;
`endif
        level_next = level_q;
        if (push && !pop) begin
            level_next = level_q + LEVEL_W'(1);
        end else if (!push && pop) begin
            level_next = level_q - LEVEL_W'(1);
        end
    end

    // Collector FSM: assembly register, FIFO storage/pointers, health state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            rd_valid_q    <= 1'b0;
            trng_req_q    <= 1'b1;
            health_fail_q <= 1'b0;
            asm_q         <= '0;
            slice_q       <= '0;
`ifdef TRNG_COLLECTOR_HEALTH_EN
            rep_cnt_q     <= '0;
            prev_q        <= '0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (trip) begin
                        // Tripping sample is dropped even if it would complete a word.
                        state_q       <= FAULT;
                        health_fail_q <= 1'b1;
                        trng_req_q    <= 1'b0;
                        rd_valid_q    <= 1'b0;
                        level_q       <= '0;
                        wr_ptr_q      <= '0;
                        rd_ptr_q      <= '0;
                        asm_q         <= '0;
                        slice_q       <= '0;
`ifdef TRNG_COLLECTOR_HEALTH_EN
                        rep_cnt_q     <= '0;
`endif
                    end else begin
                        if (accept) begin
`ifdef TRNG_COLLECTOR_HEALTH_EN
                            rep_cnt_q <= rep_next;
                            prev_q    <= bus.trng_word;
`endif
                            if (last) begin
                                slice_q <= '0;
                                asm_q   <= '0;
                            end else begin
                                slice_q <= slice_q + SLICE_W'(1);
                                asm_q   <= asm_next;
                            end
                        end
                        if (push) begin
                            mem[wr_ptr_q] <= asm_next;
                            wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
                        end
                        if (pop) begin
                            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        end
                        level_q    <= level_next;
                        rd_valid_q <= (level_next != '0);
                        trng_req_q <= (level_next < LEVEL_W'(FIFO_DEPTH));
                    end
                end
                FAULT: begin
                    trng_req_q <= 1'b0;
                    if (bus.fail_clr) begin
                        // FIFO is already empty here, so requesting resumes at once.
                        state_q       <= COLLECT;
                        health_fail_q <= 1'b0;
                        trng_req_q    <= 1'b1;
                        asm_q         <= '0;
                        slice_q       <= '0;
`ifdef TRNG_COLLECTOR_HEALTH_EN
                        rep_cnt_q     <= '0;
`endif
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.trng_req    = trng_req_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.level       = level_q;
    assign bus.rd_data     = rd_valid_q ? mem[rd_ptr_q] : '0;
`ifdef TRNG_COLLECTOR_HEALTH_EN
    assign bus.health_fail = health_fail_q;
`else
    assign bus.health_fail = health_fail_q & 1'b0;
`endif
endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: directed bench for trng_collector with default parameters.
module tb_trng_collector;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    trng_collector_if #(.TRNG_WIDTH(4), .OUT_WIDTH(32), .FIFO_DEPTH(4)) bus ();

    trng_collector #(.TRNG_WIDTH(4), .OUT_WIDTH(32), .FIFO_DEPTH(4), .REP_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] v);
        bus.trng_word  = v;
        bus.trng_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.trng_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;
    endtask

    task automatic send_1_to_8();
        for (int i = 1; i <= 8; i++) send(4'(i));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.trng_word  = '0;
        bus.trng_valid = 1'b0;
        bus.rd_ready   = 1'b0;
        bus.fail_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_health", 32'(bus.health_fail), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_trng_req", 32'(bus.trng_req), 32'd1);

        // Basic assembly: 1..8 -> 0x87654321
        send_1_to_8();
        chk("asm_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("asm_rd_data", bus.rd_data, 32'h87654321);
        chk("asm_level", 32'(bus.level), 32'd1);
        pop_one();
        chk("asm_pop_level", 32'(bus.level), 32'd0);
        chk("asm_pop_valid", 32'(bus.rd_valid), 32'd0);

        // Fill to full with sample i = (i + i/8) & 0xF
        for (int i = 0; i < 32; i++) send(4'((i + i / 8) & 15));
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_trng_req", 32'(bus.trng_req), 32'd0);
        chk("full_head", bus.rd_data, 32'h76543210);
        bus.trng_word  = 4'h3;
        bus.trng_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.trng_valid = 1'b0;
        chk("full_ignore_level", 32'(bus.level), 32'd4);
        pop_one();
        chk("room_trng_req", 32'(bus.trng_req), 32'd1);
        chk("room_level", 32'(bus.level), 32'd3);
        chk("room_head", bus.rd_data, 32'h0FEDCBA9);
        for (int i = 32; i < 40; i++) send(4'((i + i / 8) & 15));
        chk("refill_level", 32'(bus.level), 32'd4);
        chk("refill_trng_req", 32'(bus.trng_req), 32'd0);
        pop_one();
        chk("drain_w2", bus.rd_data, 32'h98765432);
        pop_one();
        chk("drain_w3", bus.rd_data, 32'h210FEDCB);
        pop_one();
        chk("drain_w4", bus.rd_data, 32'hBA987654);
        pop_one();
        chk("drain_level", 32'(bus.level), 32'd0);
        chk("drain_valid", 32'(bus.rd_valid), 32'd0);

        // Simultaneous push and pop at level 3
        send_1_to_8();
        for (int i = 9; i <= 16; i++) send(4'(i & 15));
        send_1_to_8();
        chk("pp_pre_level", 32'(bus.level), 32'd3);
        for (int i = 2; i <= 8; i++) send(4'(i));
        bus.rd_ready = 1'b1;
        send(4'h9);
        bus.rd_ready = 1'b0;
        chk("pp_level", 32'(bus.level), 32'd3);
        chk("pp_head_w2", bus.rd_data, 32'h0FEDCBA9);
        pop_one();
        chk("pp_head_w3", bus.rd_data, 32'h87654321);
        pop_one();
        chk("pp_head_w4", bus.rd_data, 32'h98765432);
        pop_one();
        chk("pp_empty", 32'(bus.level), 32'd0);

`ifdef TRNG_COLLECTOR_HEALTH_EN
        // Repetition fault flushes the FIFO and drops the tripping word
        send_1_to_8();
        chk("hl_pre_level", 32'(bus.level), 32'd1);
        for (int i = 0; i < 8; i++) send(4'hA);
        chk("hl_fail", 32'(bus.health_fail), 32'd1);
        chk("hl_trng_req", 32'(bus.trng_req), 32'd0);
        chk("hl_level", 32'(bus.level), 32'd0);
        chk("hl_rd_valid", 32'(bus.rd_valid), 32'd0);
        send(4'h5);
        chk("hl_ignore_level", 32'(bus.level), 32'd0);
        bus.fail_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.fail_clr = 1'b0;
        chk("hl_clr_fail", 32'(bus.health_fail), 32'd0);
        chk("hl_clr_req", 32'(bus.trng_req), 32'd1);
        for (int i = 0; i < 7; i++) send(4'hA);
        send(4'hB);
        chk("hl_7rep_fail", 32'(bus.health_fail), 32'd0);
        chk("hl_7rep_level", 32'(bus.level), 32'd1);
        chk("hl_7rep_data", bus.rd_data, 32'hBAAAAAAA);
        bus.fail_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.fail_clr = 1'b0;
        chk("hl_clr_noop_level", 32'(bus.level), 32'd1);
        pop_one();
`else
        // No health test: repeated samples pass straight through
        for (int i = 0; i < 8; i++) send(4'hA);
        chk("nh_level1", 32'(bus.level), 32'd1);
        chk("nh_data1", bus.rd_data, 32'hAAAAAAAA);
        for (int i = 0; i < 8; i++) send(4'hA);
        chk("nh_level2", 32'(bus.level), 32'd2);
        chk("nh_fail", 32'(bus.health_fail), 32'd0);
        pop_one();
        chk("nh_data2", bus.rd_data, 32'hAAAAAAAA);
        bus.fail_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.fail_clr = 1'b0;
        chk("nh_fail_after_clr", 32'(bus.health_fail), 32'd0);
        pop_one();
`endif
        chk("mid_empty", 32'(bus.level), 32'd0);

        // Reset mid-word with two words buffered
        send_1_to_8();
        send_1_to_8();
        send(4'h1);
        send(4'h2);
        send(4'h3);
        chk("mr_pre_level", 32'(bus.level), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mr_level", 32'(bus.level), 32'd0);
        chk("mr_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mr_rd_data", bus.rd_data, 32'h0);
        send_1_to_8();
        chk("mr_word", bus.rd_data, 32'h87654321);
        chk("mr_word_level", 32'(bus.level), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trng_collector.md
TRNG_COLLECTOR -- requirements
Module: trng_collector

Interface
REQ-001 Parameter TRNG_WIDTH, default 4: bits per raw TRNG sample.
REQ-002 Parameter OUT_WIDTH, default 32: assembled word width; SHALL be an integer multiple of TRNG_WIDTH.
REQ-003 Parameter FIFO_DEPTH, default 4: words buffered; SHALL be a power of two, >=2.
REQ-004 Parameter REP_LIMIT, default 8: consecutive identical samples that trip the health test; >=2.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 trng_word  in  TRNG_WIDTH  raw sample.
REQ-008 trng_valid  in  1  sample strobe; accepted only when trng_req=1.
REQ-009 trng_req  out  1  sample request to TRNG source.
REQ-010 rd_data  out  OUT_WIDTH  head-of-FIFO word.
REQ-011 rd_valid  out  1  FIFO non-empty.
REQ-012 rd_ready  in  1  consumer pop; pop occurs when rd_valid & rd_ready.
REQ-013 level  out  clog2(FIFO_DEPTH+1)  words held.
REQ-014 health_fail  out  1  sticky health-test failure flag.
REQ-015 fail_clr  in  1  clears a health failure.

Function
REQ-016 States: COLLECT (trng_req = level<FIFO_DEPTH), FAULT (trng_req=0).
REQ-017 Accepted sample (trng_req & trng_valid) SHALL shift into the assembly register, first sample at bits [TRNG_WIDTH-1:0], later samples at successively higher slices.
REQ-018 On the OUT_WIDTH/TRNG_WIDTH-th accepted sample the assembled word SHALL be pushed the same cycle; rd_valid rises the following cycle if FIFO was empty; slice counter wraps to 0.
REQ-019 rd_data SHALL be first-word-fall-through: valid whenever rd_valid=1, stable until popped.
REQ-020 Simultaneous push and pop SHALL leave level unchanged; pop on empty and push on full SHALL never occur (rd_valid/trng_req gating).
REQ-021 trng_req SHALL drop in the cycle level reaches FIFO_DEPTH and rise the cycle after a pop makes room; partial assembly is retained meanwhile.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 trng_valid while trng_req=0 SHALL be ignored, including in FAULT.

Reset
REQ-024 On reset: state COLLECT, level=0, rd_valid=0, rd_data=0, health_fail=0, assembly register and slice counter=0, repetition counter=0; trng_req=1 the cycle after reset deasserts.
REQ-025 Reset mid-word SHALL discard the partial word and all FIFO contents.

Configuration
REQ-026 Macro TRNG_COLLECTOR_HEALTH_EN: when defined, repetition-count health test compiled in; when undefined, no repetition counter, FAULT unreachable, health_fail tied 0, fail_clr ignored.
REQ-027 (enabled) Repetition counter SHALL be 1 on first sample after reset/clear, increment on each accepted sample equal to the previous accepted sample, reload to 1 on a differing sample.
REQ-028 (enabled) When the counter reaches REP_LIMIT: next cycle state=FAULT, health_fail=1, trng_req=0, partial word discarded, FIFO flushed (level=0, rd_valid=0); the tripping sample SHALL NOT be pushed even if it completes a word.
REQ-029 (enabled) fail_clr=1 in FAULT SHALL return to COLLECT next cycle with health_fail=0, counters=0; fail_clr outside FAULT SHALL have no effect; health_fail stays set until fail_clr.

Verification
REQ-030 Defaults, 8 samples 1,2,3,4,5,6,7,8 back-to-back -> one cycle after 8th, rd_valid=1, rd_data=0x87654321, level=1.
REQ-031 rd_ready=0, feed 40 distinct-pattern samples -> level=4 after 32nd, trng_req=0 same cycle; one pop -> trng_req=1 next cycle, remaining samples resume filling slot.
REQ-032 FIFO at level 3, last sample of word and pop in same cycle -> level stays 3, data order preserved.
REQ-033 HEALTH_EN, 8 consecutive samples 0xA -> health_fail=1, trng_req=0, level=0; then fail_clr pulse -> health_fail=0, trng_req=1; 7 repeats of 0xA then 0xB -> no fault.
REQ-034 HEALTH_EN undefined, 16 samples 0xA -> rd_data=0xAAAAAAAA twice, health_fail=0 throughout.
REQ-035 Reset asserted after 3 samples with level=2 -> next cycle level=0, rd_valid=0; subsequent 8 samples 1..8 produce 0x87654321.
